// File: rtl/fabric_cfg_pkg.sv
// -----------------------------------------------------------------------------
// fabric_cfg_pkg
// Shared definitions for the eFPGA configuration-frame loaders:
//   - cfg_state_t : loader sequencing states (HDR, DATA, STROBE)
//   - SYNC_WORD_DEFAULT : expected value of header bits [SYNC_HI:SYNC_LO]
//   - header field positions for the sync value and the frame index
// -----------------------------------------------------------------------------
package fabric_cfg_pkg;

   typedef enum logic [1:0] {
      HDR    = 2'd0,
      DATA   = 2'd1,
      STROBE = 2'd2
   } cfg_state_t;

   localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hFAB0;

   // Header word layout: [31:16] sync value, [7:0] frame index.
   localparam int SYNC_HI = 31;
   localparam int SYNC_LO = 16;
   localparam int IDX_HI  = 7;
   localparam int IDX_LO  = 0;
   localparam int IDX_W   = IDX_HI - IDX_LO + 1;

endpackage : fabric_cfg_pkg

// File: rtl/w_edge_frame_strobe_dec.sv
// -----------------------------------------------------------------------------
// w_edge_frame_strobe_dec
// Registered one-hot FrameStrobe decoder with frame-index range check.
// When 'fire' is high at a CLK edge, the next cycle shows either a single
// FrameStrobe bit (idx < MAX_FRAMES) or an out_of_range pulse; otherwise both
// outputs are zero.
//
// Ports:
//   CLK          in   configuration clock, rising edge
//   resetn       in   synchronous active-low reset
//   idx          in   frame index to decode
//   fire         in   issue a strobe for idx in the following cycle
//   FrameStrobe  out  one-hot, single-cycle frame strobe
//   out_of_range out  single-cycle pulse: idx >= MAX_FRAMES when fired
// -----------------------------------------------------------------------------
module w_edge_frame_strobe_dec
   import fabric_cfg_pkg::*;
#(
   parameter int MAX_FRAMES = 20
) (
   input  logic                  CLK,
   input  logic                  resetn,
   input  logic [IDX_W-1:0]      idx,
   input  logic                  fire,
   output logic [MAX_FRAMES-1:0] FrameStrobe,
   output logic                  out_of_range
);

   logic                  in_range;
   logic [MAX_FRAMES-1:0] onehot;

   // NOTE: every always_comb output gets a default before any branch so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      in_range = (int'(idx) < MAX_FRAMES);
      onehot   = '0;
      // Compare against each legal index rather than indexing by idx, so an
      // out-of-range index simply produces no bit.
      for (int i = 0; i < MAX_FRAMES; i++) begin
         onehot[i] = (int'(idx) == i);
      end
   end

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples the pre-edge values of its inputs.
   always_ff @(posedge CLK) begin
      if (!resetn) begin
         FrameStrobe  <= '0;
         out_of_range <= 1'b0;
      end else begin
         FrameStrobe  <= fire ? onehot : '0;
         out_of_range <= fire && !in_range;
      end
   end

endmodule : w_edge_frame_strobe_dec

// File: rtl/w_edge_frame_loader.sv
// -----------------------------------------------------------------------------
// w_edge_frame_loader
// Configuration-frame loader for the west-termination column. Accepts a header
// word followed by NUM_ROWS data words over a valid/ready stream, writes the
// words into the FrameData rows and pulses one FrameStrobe line one cycle after
// the last data word. West-termination switch matrices hold no config bits, but
// frames are still sequenced so this column tracks the interior columns.
//
// Optional build macro: W_EDGE_FRAME_LOADER_STATS_EN adds the saturating
// frames_done counter output.
//
// Ports:
//   CLK          in   configuration clock, rising edge
//   resetn       in   synchronous active-low reset
//   s_valid      in   input word valid
//   s_ready      out  loader can accept a word (low only in STROBE)
//   s_data       in   header or data word
//   FrameData    out  row r at [r*FRAME_BITS +: FRAME_BITS]
//   FrameStrobe  out  one-hot, single-cycle frame write strobe
//   busy         out  high whenever not waiting for a header
//   err_sync     out  sticky: a header carried the wrong sync value
//   err_idx      out  sticky: a frame index was out of range
//   frames_done  out  (stats build only) valid strobes issued, saturating
// -----------------------------------------------------------------------------
module w_edge_frame_loader
   import fabric_cfg_pkg::*;
#(
   parameter int          NUM_ROWS   = 16,
   parameter int          FRAME_BITS = 32,
   parameter int          MAX_FRAMES = 20,
   parameter logic [15:0] SYNC_WORD  = SYNC_WORD_DEFAULT
) (
   input  logic                           CLK,
   input  logic                           resetn,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [FRAME_BITS-1:0]          s_data,
   output logic [NUM_ROWS*FRAME_BITS-1:0] FrameData,
   output logic [MAX_FRAMES-1:0]          FrameStrobe,
   output logic                           busy,
   output logic                           err_sync,
   output logic                           err_idx
`ifdef W_EDGE_FRAME_LOADER_STATS_EN
   ,
   output logic [15:0]                    frames_done
`endif
);

   localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

   cfg_state_t       state;
   cfg_state_t       next_state;
   logic [ROW_W-1:0] row;
   logic [IDX_W-1:0] frame_idx;
   logic             xfer;
   logic             sync_ok;
   logic             last_row;
   logic             fire;
   logic             out_of_range;

   assign s_ready  = (state != STROBE);
   assign busy     = (state != HDR);
   assign xfer     = s_valid && s_ready;
   assign sync_ok  = (s_data[SYNC_HI:SYNC_LO] == SYNC_WORD);
   assign last_row = (row == ROW_W'(NUM_ROWS - 1));
   // The decoder is registered, so firing on the last data word places the
   // strobe in the STROBE cycle.
   assign fire     = (state == DATA) && xfer && last_row;

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!resetn) begin
         state <= HDR;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         HDR:     if (xfer && sync_ok) next_state = DATA;
         DATA:    if (xfer && last_row) next_state = STROBE;
         STROBE:  next_state = HDR;
         default: next_state = HDR;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath: header latch, row writes, sticky error flags
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!resetn) begin
         // NOTE: FrameData is a register bank driving the tile rows directly,
         // not a RAM, so it is cleared on reset; a partial frame never leaks.
         FrameData <= '0;
         row       <= '0;
         frame_idx <= '0;
         err_sync  <= 1'b0;
         err_idx   <= 1'b0;
      end else begin
         if (state == HDR && xfer) begin
            if (sync_ok) begin
               frame_idx <= s_data[IDX_HI:IDX_LO];
               row       <= '0;
            end else begin
               err_sync  <= 1'b1;
            end
         end

         if (state == DATA && xfer) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
               if (row == ROW_W'(r)) begin
                  FrameData[r*FRAME_BITS +: FRAME_BITS] <= s_data;
               end
            end
            // Hold on the last row; the next header clears the counter.
            if (!last_row) begin
               row <= row + 1'b1;
            end
         end

         if (out_of_range) begin
            err_idx <= 1'b1;
         end
      end
   end

   w_edge_frame_strobe_dec #(
      .MAX_FRAMES (MAX_FRAMES)
   ) u_strobe_dec (
      .CLK          (CLK),
      .resetn       (resetn),
      .idx          (frame_idx),
      .fire         (fire),
      .FrameStrobe  (FrameStrobe),
      .out_of_range (out_of_range)
   );

`ifdef W_EDGE_FRAME_LOADER_STATS_EN
   always_ff @(posedge CLK) begin
      if (!resetn) begin
         frames_done <= '0;
      end else if ((|FrameStrobe) && (frames_done != 16'hFFFF)) begin
         frames_done <= frames_done + 16'd1;
      end
   end
`endif

endmodule : w_edge_frame_loader
